// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port memory between an instruction-fetch
// port and a load/store port. One transaction at a time: grant, wait for the
// memory acknowledge (or time out), then pulse the owner's ready for a cycle.
//
// Optional build macro: MEMORY_ARBITER_ROUND_ROBIN_EN
//   defined   -> simultaneous requests alternate (data wins the first tie)
//   undefined -> data always wins a simultaneous request
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no transaction; grant on the next edge if any valid is high
// ST_BUSY    | memory_request high, waiting for acknowledge or timeout
// ST_RESPOND | owner's ready pulses with registered response for one cycle
module memory_arbiter #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [ADDRESS_WIDTH-1:0] fetch_address,
    output logic                     fetch_ready,
    input  logic                     data_valid,
    input  logic [ADDRESS_WIDTH-1:0] data_address,
    input  logic                     data_write_enable,
    input  logic [31:0]              data_write_data,
    output logic                     data_ready,
    output logic [31:0]              response_read_data,
    output logic                     response_error,
    output logic                     memory_request,
    output logic [ADDRESS_WIDTH-1:0] memory_address,
    output logic                     memory_write_enable,
    output logic [31:0]              memory_write_data,
    input  logic                     memory_acknowledge,
    input  logic [31:0]              memory_read_data
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Counter reads 0 in the first BUSY cycle, so the last allowed cycle is N-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic [31:0]              wdata_q, wdata_d;
    logic                     owner_data_q, owner_data_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic                     grant_data;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic last_data_q, last_data_d;

    // On a tie, data wins unless it was the last port granted.
    assign grant_data = data_valid && (!fetch_valid || !last_data_q);
`else
    assign grant_data = data_valid;
`endif

    // Next-state, grant latching, busy counter and response capture.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        owner_data_d = owner_data_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        last_data_d  = last_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fetch_valid || data_valid) begin
                    state_d      = ST_BUSY;
                    owner_data_d = grant_data;
                    addr_d       = grant_data ? data_address : fetch_address;
                    we_d         = grant_data && data_write_enable;
                    wdata_d      = grant_data ? data_write_data : 32'd0;
                    cnt_d        = '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
                    last_data_d  = grant_data;
`endif
                end
            end
            ST_BUSY: begin
                // An acknowledge in the final allowed cycle still counts.
                if (memory_acknowledge) begin
                    state_d = ST_RESPOND;
                    rdata_d = memory_read_data;
                    err_d   = 1'b0;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d = ST_RESPOND;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State and latched-field registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= 32'd0;
            owner_data_q <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_data_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            owner_data_q <= owner_data_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_data_q  <= last_data_d;
`endif
        end
    end

    assign memory_request      = (state_q == ST_BUSY);
    assign memory_address      = addr_q;
    assign memory_write_enable = we_q;
    assign memory_write_data   = wdata_q;
    assign fetch_ready         = (state_q == ST_RESPOND) && !owner_data_q;
    assign data_ready          = (state_q == ST_RESPOND) && owner_data_q;
    assign response_read_data  = rdata_q;
    assign response_error      = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized transactions for
// memory_arbiter. The reference is transaction-level: who should win, how many
// BUSY cycles the request lasts, and what the response should be.
module tb_memory_arbiter;

    localparam int TO = 4;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_address;
    logic        fetch_ready;
    logic        data_valid;
    logic [31:0] data_address;
    logic        data_write_enable;
    logic [31:0] data_write_data;
    logic        data_ready;
    logic [31:0] response_read_data;
    logic        response_error;
    logic        memory_request;
    logic [31:0] memory_address;
    logic        memory_write_enable;
    logic [31:0] memory_write_data;
    logic        memory_acknowledge;
    logic [31:0] memory_read_data;

    int n_checks = 0;
    int n_fails  = 0;
    bit m_last_data = 1'b0;

    memory_arbiter #(
        .ADDRESS_WIDTH (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .fetch_valid        (fetch_valid),
        .fetch_address      (fetch_address),
        .fetch_ready        (fetch_ready),
        .data_valid         (data_valid),
        .data_address       (data_address),
        .data_write_enable  (data_write_enable),
        .data_write_data    (data_write_data),
        .data_ready         (data_ready),
        .response_read_data (response_read_data),
        .response_error     (response_error),
        .memory_request     (memory_request),
        .memory_address     (memory_address),
        .memory_write_enable(memory_write_enable),
        .memory_write_data  (memory_write_data),
        .memory_acknowledge (memory_acknowledge),
        .memory_read_data   (memory_read_data)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic refresh_fields();
        if (!fetch_valid) fetch_address = $urandom;
        if (!data_valid) begin
            data_address      = $urandom;
            data_write_enable = 1'($urandom_range(0, 1));
            data_write_data   = $urandom;
        end
    endtask

    // Called at a negedge while the arbiter is idle; returns at the negedge of
    // the idle cycle after the response.
    task automatic run_txn(input bit new_f, input bit new_d, input int ack_at,
                           input logic [31:0] rdata, input bit drop, output bit saw_data);
        bit          win_d;
        bit          exp_err;
        bit          exp_we;
        int          busy_len;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        if (new_f) fetch_valid = 1'b1;
        if (new_d) data_valid = 1'b1;
        if (!fetch_valid && !data_valid) data_valid = 1'b1;
        if (fetch_valid && data_valid) win_d = RR ? !m_last_data : 1'b1;
        else win_d = data_valid;
        m_last_data = win_d;
        exp_addr = win_d ? data_address : fetch_address;
        exp_we   = win_d ? data_write_enable : 1'b0;
        exp_wd   = data_write_data;
        exp_err  = (TO != 0) && (ack_at > TO);
        busy_len = exp_err ? TO : ack_at;
        exp_rd   = exp_err ? 32'd0 : rdata;
        for (int b = 1; b <= busy_len; b++) begin
            @(negedge clock);
            check_eq("mem_request_busy", memory_request, 1);
            check_eq("mem_address", memory_address, exp_addr);
            check_eq("mem_write_enable", memory_write_enable, exp_we);
            if (win_d) check_eq("mem_write_data", memory_write_data, exp_wd);
            check_eq("ready_during_busy", {fetch_ready, data_ready}, 0);
            memory_acknowledge = (b == ack_at);
            memory_read_data   = (b == ack_at) ? rdata : $urandom;
            if (drop && b == 1) begin
                if (win_d) begin
                    data_valid        = 1'b0;
                    data_address      = $urandom;
                    data_write_data   = $urandom;
                    data_write_enable = ~data_write_enable;
                end else begin
                    fetch_valid   = 1'b0;
                    fetch_address = $urandom;
                end
            end
        end
        @(negedge clock);
        check_eq("mem_request_respond", memory_request, 0);
        check_eq("ready_owner", {fetch_ready, data_ready}, win_d ? 2'b01 : 2'b10);
        check_eq("resp_read_data", response_read_data, exp_rd);
        check_eq("resp_error", response_error, exp_err);
        saw_data = data_ready;
        memory_acknowledge = 1'($urandom_range(0, 1));
        memory_read_data   = $urandom;
        if (win_d) data_valid = 1'b0;
        else fetch_valid = 1'b0;
        @(negedge clock);
        check_eq("ready_after_pulse", {fetch_ready, data_ready}, 0);
        check_eq("mem_request_idle", memory_request, 0);
        check_eq("resp_hold_data", response_read_data, exp_rd);
        check_eq("resp_hold_error", response_error, exp_err);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        m_last_data = 1'b0;
    endtask

    task automatic drain();
        bit s;
        for (int i = 0; i < 4 && (fetch_valid || data_valid); i++) begin
            refresh_fields();
            run_txn(1'b0, 1'b0, 1, $urandom, 1'b0, s);
        end
    endtask

    // Stimulus and checking sequence.
    initial begin
        bit s;
        reset              = 1'b0;
        fetch_valid        = 1'b0;
        data_valid         = 1'b0;
        fetch_address      = '0;
        data_address       = '0;
        data_write_enable  = 1'b0;
        data_write_data    = '0;
        memory_acknowledge = 1'b0;
        memory_read_data   = '0;
        repeat (2) @(negedge clock);
        check_eq("rst_mem_request", memory_request, 0);
        check_eq("rst_mem_address", memory_address, 0);
        check_eq("rst_ready", {fetch_ready, data_ready}, 0);
        check_eq("rst_resp", {response_error, response_read_data}, 0);
        reset = 1'b1;

        // Fetch 0x100, immediate acknowledge.
        fetch_address = 32'h100;
        run_txn(1'b1, 1'b0, 1, 32'h0000_0013, 1'b0, s);
        check_eq("fetch_owner", s, 0);

        // Store 0xDEADBEEF to 0x2000, acknowledge in the fourth BUSY cycle.
        data_address      = 32'h2000;
        data_write_enable = 1'b1;
        data_write_data   = 32'hDEAD_BEEF;
        run_txn(1'b0, 1'b1, 4, $urandom, 1'b0, s);
        check_eq("store_owner", s, 1);

        // Both valids held across four transactions from a fresh reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            refresh_fields();
            run_txn(1'b1, 1'b1, 1, $urandom, 1'b0, s);
            check_eq("tie_sequence", s, RR ? ((i % 2) == 0) : 1'b1);
        end
        drain();

        // Fetch with no acknowledge times out.
        refresh_fields();
        run_txn(1'b1, 1'b0, 100, $urandom, 1'b0, s);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            refresh_fields();
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 6), $urandom, ($urandom_range(0, 7) == 0), s);
        end
        drain();

        // Reset in the second BUSY cycle of a load, then clean re-grant.
        refresh_fields();
        data_valid         = 1'b1;
        data_write_enable  = 1'b0;
        memory_acknowledge = 1'b0;
        @(negedge clock);
        check_eq("abort_busy1", memory_request, 1);
        @(negedge clock);
        check_eq("abort_busy2", memory_request, 1);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_mem_request", memory_request, 0);
        check_eq("abort_mem_fields", {memory_address, memory_write_enable}, 0);
        check_eq("abort_mem_wdata", memory_write_data, 0);
        check_eq("abort_resp", {response_error, response_read_data}, 0);
        check_eq("abort_ready", {fetch_ready, data_ready}, 0);
        @(negedge clock);
        check_eq("abort_no_ready", {fetch_ready, data_ready}, 0);
        check_eq("abort_held_idle", memory_request, 0);
        reset = 1'b1;
        m_last_data = 1'b0;
        run_txn(1'b0, 1'b0, 2, $urandom, 1'b0, s);
        check_eq("regrant_owner", s, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
